ram_bist: RTL and testbench

- March-test initiator for the single-port `ram` block (ports `clk`, `wr`, `addr`, `din`, `dout`).
- Drives the RAM's write side and checks its read data through a 4-element March sequence: W0 up, R0W1 up, R1W0 down, R0 up.
- Reports pass/fail and the first failing address and data.
- Sits between the `ram` instance and the system self-test control.

---
 rtl/ram_bist_pkg.sv | 23 ++
 rtl/ram_bist_addr_gen.sv | 61 ++++++
 rtl/ram_bist.sv | 245 ++++++++++++++++++++++++
 tb/tb_ram_bist.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/ram_bist_pkg.sv
// ram_bist_pkg: shared types for the March-test BIST block.
//   bist_state_t : FSM states of the March sequence W0^, R0W1^, R1W0v, R0^
//   dir_t        : address march direction for the address generator
package ram_bist_pkg;

  typedef enum logic [3:0] {
    IDLE  = 4'd0,
    M0_W  = 4'd1,
    M1_R  = 4'd2,
    M1_W  = 4'd3,
    M2_R  = 4'd4,
    M2_W  = 4'd5,
    M3_R  = 4'd6,
    FLUSH = 4'd7,
    DONE  = 4'd8
  } bist_state_t;

  typedef enum logic {
    UP   = 1'b0,
    DOWN = 1'b1
  } dir_t;

endpackage

// File: rtl/ram_bist_addr_gen.sv
// ram_bist_addr_gen: N-bit up/down address counter for the March test.
//   clk, rst_n : clock, async active-low reset (address resets to 0)
//   load_zero  : load address 0 (highest priority)
//   load_max   : load address D-1
//   step       : advance one address in direction dir
//   dir        : UP increments, DOWN decrements
//   addr       : current address
//   last       : combinational terminal flag (D-1 when UP, 0 when DOWN)
module ram_bist_addr_gen
  import ram_bist_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_zero,
  input  logic         load_max,
  input  logic         step,
  input  dir_t         dir,
  output logic [N-1:0] addr,
  output logic         last
);

  localparam logic [N-1:0] ADDR_ZERO = {N{1'b0}};
  localparam logic [N-1:0] ADDR_MAX  = {N{1'b1}};
  localparam logic [N-1:0] ADDR_ONE  = {{(N-1){1'b0}}, 1'b1};

  logic [N-1:0] addr_r;

  // Address register: loads have priority over stepping; never wraps because
  // the FSM reloads at the terminal address instead of stepping past it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_r <= ADDR_ZERO;
    end else if (load_zero) begin
      addr_r <= ADDR_ZERO;
    end else if (load_max) begin
      addr_r <= ADDR_MAX;
    end else if (step) begin
      if (dir == UP) begin
        addr_r <= addr_r + ADDR_ONE;
      end else begin
        addr_r <= addr_r - ADDR_ONE;
      end
    end else begin
      addr_r <= addr_r;
    end
  end

  // Terminal-address detect for the current march direction.
  always_comb begin
    if (dir == UP) begin
      last = (addr_r == ADDR_MAX);
    end else begin
      last = (addr_r == ADDR_ZERO);
    end
  end

  assign addr = addr_r;

endmodule

// File: rtl/ram_bist.sv
// ram_bist: March-test initiator for a single-port, read-first RAM with
// 1-cycle read latency. Sequence: W0 up, R0W1 up, R1W0 down, R0 up.
//   clk, rst_n  : clock, async active-low reset (aborts a running test)
//   start       : one-cycle request, sampled only in IDLE
//   busy        : high in every state except IDLE (6D+2 cycles per test)
//   done        : one-cycle pulse in the DONE state
//   pass        : result of the last completed test, cleared on accepted start
//   fail_addr   : address of the first miscompare
//   fail_data   : RAM data observed at the first miscompare
//   ram_wr, ram_addr, ram_din : RAM write side
//   ram_dout    : RAM read data
module ram_bist
  import ram_bist_pkg::*;
#(
  parameter int          N   = 4,
  parameter int          M   = 8,
  parameter logic [M-1:0] PAT = {M{1'b0}}
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  output logic         busy,
  output logic         done,
  output logic         pass,
  output logic [N-1:0] fail_addr,
  output logic [M-1:0] fail_data,
  output logic         ram_wr,
  output logic [N-1:0] ram_addr,
  output logic [M-1:0] ram_din,
  input  logic [M-1:0] ram_dout
);

  bist_state_t  state_r;
  logic         busy_r;
  logic         done_r;
  logic         pass_r;
  logic         error_r;
  logic [N-1:0] fail_addr_r;
  logic [M-1:0] fail_data_r;
  logic         ram_wr_r;
  logic [M-1:0] ram_din_r;
  logic         check_valid_r;
  logic [N-1:0] check_addr_r;

  logic         load_zero_s;
  logic         load_max_s;
  logic         step_s;
  dir_t         dir_s;
  logic         last_s;
  logic [N-1:0] addr_s;
  logic         mis_s;
  logic [N-1:0] mis_addr_s;

  ram_bist_addr_gen #(.N(N)) u_addr_gen (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_zero (load_zero_s),
    .load_max  (load_max_s),
    .step      (step_s),
    .dir       (dir_s),
    .addr      (addr_s),
    .last      (last_s)
  );

  // Address-generator control: R states hold the address so that each
  // read/write pair targets the same cell; terminal addresses reload.
  always_comb begin
    load_zero_s = 1'b0;
    load_max_s  = 1'b0;
    step_s      = 1'b0;
    dir_s       = UP;
    case (state_r)
      IDLE: begin
        if (start) begin
          load_zero_s = 1'b1;
        end else begin
          load_zero_s = 1'b0;
        end
      end
      M0_W: begin
        if (last_s) begin
          load_zero_s = 1'b1;
        end else begin
          step_s = 1'b1;
        end
      end
      M1_W: begin
        if (last_s) begin
          load_max_s = 1'b1;
        end else begin
          step_s = 1'b1;
        end
      end
      M2_R: begin
        dir_s = DOWN;
      end
      M2_W: begin
        dir_s = DOWN;
        if (last_s) begin
          load_zero_s = 1'b1;
        end else begin
          step_s = 1'b1;
        end
      end
      M3_R: begin
        if (last_s) begin
          step_s = 1'b0;
        end else begin
          step_s = 1'b1;
        end
      end
      default: begin
        step_s = 1'b0;
      end
    endcase
  end

  // Miscompare detect. M1/M2 compare in the W cycle (read data of the
  // preceding R cycle); M3 uses the registered check stage because reads
  // are issued back to back and the address has already moved on.
  always_comb begin
    mis_s      = 1'b0;
    mis_addr_s = ram_addr;
    if (check_valid_r) begin
      mis_s      = (ram_dout != PAT);
      mis_addr_s = check_addr_r;
    end else if (state_r == M1_W) begin
      mis_s = (ram_dout != PAT);
    end else if (state_r == M2_W) begin
      mis_s = (ram_dout != ~PAT);
    end else begin
      mis_s = 1'b0;
    end
  end

  // Main FSM with registered outputs, M3 compare pipeline and fail capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= IDLE;
      busy_r        <= 1'b0;
      done_r        <= 1'b0;
      pass_r        <= 1'b0;
      error_r       <= 1'b0;
      fail_addr_r   <= {N{1'b0}};
      fail_data_r   <= {M{1'b0}};
      ram_wr_r      <= 1'b0;
      ram_din_r     <= {M{1'b0}};
      check_valid_r <= 1'b0;
      check_addr_r  <= {N{1'b0}};
    end else begin
      done_r        <= 1'b0;
      check_valid_r <= (state_r == M3_R);
      check_addr_r  <= ram_addr;
      // First miscompare only; later ones leave the capture untouched.
      if (mis_s && !error_r) begin
        error_r     <= 1'b1;
        fail_addr_r <= mis_addr_s;
        fail_data_r <= ram_dout;
      end else begin
        error_r     <= error_r;
      end
      case (state_r)
        IDLE: begin
          if (start) begin
            state_r     <= M0_W;
            busy_r      <= 1'b1;
            ram_wr_r    <= 1'b1;
            ram_din_r   <= PAT;
            error_r     <= 1'b0;
            fail_addr_r <= {N{1'b0}};
            fail_data_r <= {M{1'b0}};
            pass_r      <= 1'b0;
          end else begin
            state_r <= IDLE;
          end
        end
        M0_W: begin
          if (last_s) begin
            state_r  <= M1_R;
            ram_wr_r <= 1'b0;
          end else begin
            state_r <= M0_W;
          end
        end
        M1_R: begin
          state_r   <= M1_W;
          ram_wr_r  <= 1'b1;
          ram_din_r <= ~PAT;
        end
        M1_W: begin
          ram_wr_r <= 1'b0;
          if (last_s) begin
            state_r <= M2_R;
          end else begin
            state_r <= M1_R;
          end
        end
        M2_R: begin
          state_r   <= M2_W;
          ram_wr_r  <= 1'b1;
          ram_din_r <= PAT;
        end
        M2_W: begin
          ram_wr_r <= 1'b0;
          if (last_s) begin
            state_r <= M3_R;
          end else begin
            state_r <= M2_R;
          end
        end
        M3_R: begin
          if (last_s) begin
            state_r <= FLUSH;
          end else begin
            state_r <= M3_R;
          end
        end
        FLUSH: begin
          state_r <= DONE;
          done_r  <= 1'b1;
        end
        DONE: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
          pass_r  <= ~error_r;
        end
        default: begin
          state_r  <= IDLE;
          busy_r   <= 1'b0;
          ram_wr_r <= 1'b0;
        end
      endcase
    end
  end

  assign busy      = busy_r;
  assign done      = done_r;
  assign pass      = pass_r;
  assign fail_addr = fail_addr_r;
  assign fail_data = fail_data_r;
  assign ram_wr    = ram_wr_r;
  assign ram_addr  = addr_s;
  assign ram_din   = ram_din_r;

endmodule

// File: tb/tb_ram_bist.sv
// tb_ram_bist: table-driven bench for ram_bist (N=4, M=8, PAT=8'h00) with a
// behavioural read-first RAM carrying selectable injected faults.
module tb_ram_bist;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       busy;
  logic       done;
  logic       pass;
  logic [3:0] fail_addr;
  logic [7:0] fail_data;
  logic       ram_wr;
  logic [3:0] ram_addr;
  logic [7:0] ram_din;
  logic [7:0] ram_dout;

  int tests_run = 0;
  int tests_failed = 0;
  int fault_mode = 0;

  logic [7:0] mem [0:15];

  ram_bist #(.N(4), .M(8), .PAT(8'h00)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .fail_addr (fail_addr),
    .fail_data (fail_data),
    .ram_wr    (ram_wr),
    .ram_addr  (ram_addr),
    .ram_din   (ram_din),
    .ram_dout  (ram_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // 1: addr 9 bit0 stuck-at-1; 2: addr 3 reads FF; 4: addr 6 bit2 stuck-at-0
  function automatic logic [7:0] rd_fault(input logic [7:0] v, input logic [3:0] a);
    logic [7:0] r;
    r = v;
    if (fault_mode == 1 && a == 4'h9) r = v | 8'h01;
    else if (fault_mode == 2 && a == 4'h3) r = 8'hFF;
    else if (fault_mode == 4 && a == 4'h6) r = v & 8'hFB;
    return r;
  endfunction

  // 3: addr 12 bit7 cannot make a 1->0 transition
  function automatic logic [7:0] wr_fault(input logic [7:0] d, input logic [7:0] old, input logic [3:0] a);
    logic [7:0] r;
    r = d;
    if (fault_mode == 3 && a == 4'hC) r = d | (old & 8'h80);
    return r;
  endfunction

  always @(posedge clk) begin
    ram_dout <= rd_fault(mem[ram_addr], ram_addr);
    if (ram_wr) mem[ram_addr] <= wr_fault(ram_din, mem[ram_addr], ram_addr);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Expected write-side trace per cycle after start acceptance (cycle 1 = M0 addr 0).
  task automatic trace_exp(input int cyc, output logic ew, output int ea, output logic [7:0] ed);
    int k;
    ea = -1;
    ed = 8'h00;
    if (cyc <= 16) begin
      ew = 1'b1; ea = cyc - 1; ed = 8'h00;
    end else if (cyc <= 48) begin
      k = cyc - 17; ew = k[0]; ea = k / 2; ed = 8'hFF;
    end else if (cyc <= 80) begin
      k = cyc - 49; ew = k[0]; ea = 15 - k / 2; ed = 8'h00;
    end else if (cyc <= 96) begin
      ew = 1'b0; ea = cyc - 81;
    end else begin
      ew = 1'b0;
    end
  endtask

  task automatic run_test(input int fault, input int start_at, input int rst_at,
                          output int busy_cnt, output int done_cnt, output int done_cyc,
                          output int trace_err, output logic pass_at1);
    logic ew;
    int ea;
    logic [7:0] ed;
    busy_cnt = 0; done_cnt = 0; done_cyc = 0; trace_err = 0; pass_at1 = 1'b1;
    fault_mode = fault;
    @(negedge clk);
    start = 1'b1;
    for (int cyc = 1; cyc <= 110; cyc++) begin
      @(negedge clk);
      start = (cyc == start_at);
      if (busy) busy_cnt++;
      if (done) begin done_cnt++; done_cyc = cyc; end
      if (cyc == 1) pass_at1 = pass;
      if ((rst_at == 0 || cyc <= rst_at) && cyc <= 98) begin
        trace_exp(cyc, ew, ea, ed);
        if (ram_wr !== ew) trace_err++;
        if (ea >= 0 && int'(ram_addr) != ea) trace_err++;
        if (ew && ram_din !== ed) trace_err++;
      end
      if (rst_at != 0 && cyc == rst_at) begin
        rst_n = 1'b0;
        #1;
        check("abort_ram_wr", 32'(ram_wr), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_pass", 32'(pass), 32'd0);
      end
      if (rst_at != 0 && cyc == rst_at + 3) rst_n = 1'b1;
    end
    start = 1'b0;
  endtask

  typedef struct {
    string      name;
    int         fault;
    int         start_at;
    int         rst_at;
    int         exp_busy;
    int         exp_done_cnt;
    int         exp_done_cyc;
    logic       exp_pass;
    logic [3:0] exp_fa;
    logic [7:0] exp_fd;
  } vec_t;

  vec_t vecs [8];

  initial begin
    int bc, dc, dcyc, terr;
    logic p1;
    vecs[0] = '{"good",       0,  0,  0, 98, 1, 98, 1'b1, 4'h0, 8'h00};
    vecs[1] = '{"sa1_a9",     1,  0,  0, 98, 1, 98, 1'b0, 4'h9, 8'h01};
    vecs[2] = '{"ff_a3",      2,  0,  0, 98, 1, 98, 1'b0, 4'h3, 8'hFF};
    vecs[3] = '{"tf_a12_m3",  3,  0,  0, 98, 1, 98, 1'b0, 4'hC, 8'h80};
    vecs[4] = '{"sa0_a6_m2",  4,  0,  0, 98, 1, 98, 1'b0, 4'h6, 8'hFB};
    vecs[5] = '{"good_rerun", 0,  0,  0, 98, 1, 98, 1'b1, 4'h0, 8'h00};
    vecs[6] = '{"start_at40", 0, 40,  0, 98, 1, 98, 1'b1, 4'h0, 8'h00};
    vecs[7] = '{"rst_at50",   0,  0, 50, 50, 0,  0, 1'b0, 4'h0, 8'h00};

    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    ram_dout = 8'h00;
    start = 1'b0;
    rst_n = 1'b0;
    #12;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_pass", 32'(pass), 32'd0);
    check("rst_ram_wr", 32'(ram_wr), 32'd0);
    check("rst_ram_din", 32'(ram_din), 32'd0);
    check("rst_fail_addr", 32'(fail_addr), 32'd0);
    check("rst_fail_data", 32'(fail_data), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int v = 0; v < 8; v++) begin
      run_test(vecs[v].fault, vecs[v].start_at, vecs[v].rst_at, bc, dc, dcyc, terr, p1);
      check({vecs[v].name, "_busy_cycles"}, 32'(bc), 32'(vecs[v].exp_busy));
      check({vecs[v].name, "_done_count"}, 32'(dc), 32'(vecs[v].exp_done_cnt));
      check({vecs[v].name, "_done_cycle"}, 32'(dcyc), 32'(vecs[v].exp_done_cyc));
      check({vecs[v].name, "_pass"}, 32'(pass), 32'(vecs[v].exp_pass));
      check({vecs[v].name, "_fail_addr"}, 32'(fail_addr), 32'(vecs[v].exp_fa));
      check({vecs[v].name, "_fail_data"}, 32'(fail_data), 32'(vecs[v].exp_fd));
      check({vecs[v].name, "_pass_clr_on_start"}, 32'(p1), 32'd0);
      check({vecs[v].name, "_addr_trace"}, 32'(terr), 32'd0);
    end

    // Fresh test after the aborted one must complete and pass.
    run_test(0, 0, 0, bc, dc, dcyc, terr, p1);
    check("post_rst_busy_cycles", 32'(bc), 32'd98);
    check("post_rst_done_cycle", 32'(dcyc), 32'd98);
    check("post_rst_pass", 32'(pass), 32'd1);
    check("post_rst_trace", 32'(terr), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
